// File: rtl/mem_wb_hazard_unit.sv
// mem_wb_hazard_unit: memory and writeback stage datapath for the 5-stage RV32 core.
//
// Contents:
//   - 256-byte little-endian data RAM. Byte, halfword and word stores take one cycle.
//     Loads are combinational and sign- or zero-extend the result. Addresses wrap
//     modulo 256, and misaligned accesses are allowed.
//   - Character output port. Any store that writes byte address 0xFF latches that
//     byte and pulses char_valid for one cycle.
//   - Load-use hazard detector, which drives not_stall.
//   - Writeback result multiplexer, which drives the register-file write data.
//
// Ports:
//   clock, clear          rising-edge clock; synchronous active-low reset
//   mem_addr/wdata/write  MEM-stage access address, store data and store enable
//   mem_func3             access size/sign (RISC-V funct3)
//   mem_rdata             extended load data (combinational)
//   ex_mem_read, ex_rd    EX-stage load flag and destination register
//   id_rs1, id_rs2        ID-stage source registers
//   not_stall             0 = freeze PC and IF/ID, insert a bubble into ID/EX
//   wb_sel                {offset_to_reg, mem_to_reg}
//   wb_mem_data/alu_result/branch_addr/next_pc  writeback candidates
//   wb_data               register write data (combinational)
//   char_out, char_valid  last byte stored to 0xFF, plus a one-cycle strobe
module mem_wb_hazard_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_write,
  input  logic [2:0]  mem_func3,
  output logic [31:0] mem_rdata,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        not_stall,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] wb_mem_data,
  input  logic [31:0] wb_alu_result,
  input  logic [31:0] wb_branch_addr,
  input  logic [31:0] wb_next_pc,
  output logic [31:0] wb_data,
  output logic [7:0]  char_out,
  output logic        char_valid
);

  logic [7:0]       mem_q [256];
  logic [3:0][7:0]  lane_addr;
  logic [3:0][7:0]  lane_data;
  logic [3:0]       lane_en;
  logic [3:0][7:0]  rd_byte;

  // Lane k touches byte address mem_addr+k. The 8-bit sum wraps the access past 0xFF.
  assign lane_addr[0] = mem_addr;
  assign lane_addr[1] = mem_addr + 8'd1;
  assign lane_addr[2] = mem_addr + 8'd2;
  assign lane_addr[3] = mem_addr + 8'd3;
  assign lane_data    = mem_wdata;

  always_comb begin
    lane_en = 4'b0000;
    if (mem_write) begin
      unique case (mem_func3[1:0])
        2'b00:   lane_en = 4'b0001;
        2'b01:   lane_en = 4'b0011;
        default: lane_en = 4'b1111;
      endcase
    end
  end

  // One register per RAM byte. Each byte checks whether any active lane targets it.
  for (genvar i = 0; i < 256; i++) begin : g_byte
    localparam logic [7:0] ByteIdx = 8'(i);
    logic       we;
    logic [7:0] wd;
    logic [7:0] byte_q;

    always_comb begin
      we = 1'b0;
      wd = 8'h00;
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k] && (lane_addr[k] == ByteIdx)) begin
          we = 1'b1;
          wd = lane_data[k];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (!clear) begin
        byte_q <= 8'h00;
      end else if (we) begin
        byte_q <= wd;
      end
    end

    assign mem_q[i] = byte_q;
  end

  // Character port. At most one lane of a 4-byte access can land on 0xFF.
  logic       char_hit;
  logic [7:0] char_byte;
  logic [7:0] char_out_q;
  logic       char_valid_q;

  always_comb begin
    char_hit  = 1'b0;
    char_byte = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (lane_en[k] && (lane_addr[k] == 8'hFF)) begin
        char_hit  = 1'b1;
        char_byte = lane_data[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
    end else begin
      char_valid_q <= char_hit;
      if (char_hit) begin
        char_out_q <= char_byte;
      end
    end
  end

  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;

  // Combinational load. A load in the same cycle as a store sees the old contents.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_byte[k] = mem_q[lane_addr[k]];
    end
  end

  always_comb begin
    mem_rdata = rd_byte;
    case (mem_func3)
      3'b000:  mem_rdata = {{24{rd_byte[0][7]}}, rd_byte[0]};
      3'b001:  mem_rdata = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
      3'b100:  mem_rdata = {24'h000000, rd_byte[0]};
      3'b101:  mem_rdata = {16'h0000, rd_byte[1], rd_byte[0]};
      default: mem_rdata = rd_byte;
    endcase
  end

  // Load-use hazard. x0 never carries a real dependency.
  assign not_stall = !(ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2)));

  always_comb begin
    wb_data = wb_alu_result;
    unique case (wb_sel)
      2'b00: wb_data = wb_alu_result;
      2'b01: wb_data = wb_mem_data;
      2'b10: wb_data = wb_branch_addr;
      2'b11: wb_data = wb_next_pc;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_hazard_unit.sv
module tb_mem_wb_hazard_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        not_stall;
  logic [1:0]  wb_sel;
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_branch_addr;
  logic [31:0] wb_next_pc;
  logic [31:0] wb_data;
  logic [7:0]  char_out;
  logic        char_valid;

  mem_wb_hazard_unit dut (
    .clock          (clock),
    .clear          (clear),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_write      (mem_write),
    .mem_func3      (mem_func3),
    .mem_rdata      (mem_rdata),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .not_stall      (not_stall),
    .wb_sel         (wb_sel),
    .wb_mem_data    (wb_mem_data),
    .wb_alu_result  (wb_alu_result),
    .wb_branch_addr (wb_branch_addr),
    .wb_next_pc     (wb_next_pc),
    .wb_data        (wb_data),
    .char_out       (char_out),
    .char_valid     (char_valid)
  );

  always #5 clock = ~clock;

  localparam int SelRdata = 0;
  localparam int SelStall = 1;
  localparam int SelWb    = 2;
  localparam int SelChar  = 3;
  localparam int SelValid = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: at each falling edge, compare every expectation queued for this cycle.
  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] got;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sel)
        SelRdata: got = mem_rdata;
        SelStall: got = {31'b0, not_stall};
        SelWb:    got = wb_data;
        SelChar:  got = {24'b0, char_out};
        default:  got = {31'b0, char_valid};
      endcase
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic access(input logic wr, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] d);
    mem_write = wr;
    mem_func3 = f3;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic load_chk(input string name, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] exp);
    access(1'b0, f3, a, 32'h0);
    push_exp(name, SelRdata, exp);
    tick();
  endtask

  task automatic hz_chk(input string name, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic exp);
    ex_mem_read = mr;
    ex_rd       = rd;
    id_rs1      = r1;
    id_rs2      = r2;
    push_exp(name, SelStall, {31'b0, exp});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear          = 1'b0;
    access(1'b0, 3'b010, 8'h00, 32'h0);
    ex_mem_read    = 1'b0;
    ex_rd          = 5'd0;
    id_rs1         = 5'd0;
    id_rs2         = 5'd0;
    wb_sel         = 2'b00;
    wb_alu_result  = 32'd1;
    wb_mem_data    = 32'd2;
    wb_branch_addr = 32'd3;
    wb_next_pc     = 32'd4;
    tick();
    tick();
    clear = 1'b1;

    // Reset state
    access(1'b0, 3'b010, 8'h10, 32'h0);
    push_exp("reset_rdata", SelRdata, 32'h0);
    push_exp("reset_char_out", SelChar, 32'h0);
    push_exp("reset_char_valid", SelValid, 32'h0);
    push_exp("reset_not_stall", SelStall, 32'h1);
    push_exp("reset_wb_data", SelWb, 32'd1);
    tick();

    // Word store; a same-cycle load still sees the old contents
    access(1'b1, 3'b010, 8'h10, 32'h8081_82F3);
    push_exp("sw_same_cycle_old", SelRdata, 32'h0);
    tick();
    load_chk("lw_10", 3'b010, 8'h10, 32'h8081_82F3);
    load_chk("lb_10", 3'b000, 8'h10, 32'hFFFF_FFF3);
    load_chk("lbu_10", 3'b100, 8'h10, 32'h0000_00F3);
    load_chk("lh_12", 3'b001, 8'h12, 32'hFFFF_8081);
    load_chk("lhu_12", 3'b101, 8'h12, 32'h0000_8081);
    load_chk("raw_f3_011", 3'b011, 8'h10, 32'h8081_82F3);

    // Byte and halfword stores
    access(1'b1, 3'b000, 8'h11, 32'h0000_00AA);
    tick();
    load_chk("lw_10_after_sb", 3'b010, 8'h10, 32'h8081_AAF3);
    access(1'b1, 3'b001, 8'h20, 32'hFFFF_1234);
    tick();
    load_chk("lw_20_after_sh", 3'b010, 8'h20, 32'h0000_1234);

    // Wrapping word store across 0xFF
    access(1'b1, 3'b010, 8'hFE, 32'h4443_4241);
    push_exp("char_valid_during_store", SelValid, 32'h0);
    tick();
    access(1'b0, 3'b100, 8'hFE, 32'h0);
    push_exp("char_out_after_ff", SelChar, 32'h42);
    push_exp("char_valid_pulse", SelValid, 32'h1);
    push_exp("lbu_fe", SelRdata, 32'h41);
    tick();
    access(1'b0, 3'b100, 8'hFF, 32'h0);
    push_exp("char_valid_drop", SelValid, 32'h0);
    push_exp("char_out_hold", SelChar, 32'h42);
    push_exp("lbu_ff", SelRdata, 32'h42);
    tick();
    load_chk("lbu_00_wrap", 3'b100, 8'h00, 32'h43);
    load_chk("lbu_01_wrap", 3'b100, 8'h01, 32'h44);
    load_chk("lw_fe_wrap", 3'b010, 8'hFE, 32'h4443_4241);

    // Hazard detector
    hz_chk("hz_rs2_match", 1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
    hz_chk("hz_rs1_match", 1'b1, 5'd5, 5'd5, 5'd9, 1'b0);
    hz_chk("hz_rd_zero", 1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    hz_chk("hz_no_load", 1'b0, 5'd5, 5'd5, 5'd0, 1'b1);
    hz_chk("hz_no_match", 1'b1, 5'd7, 5'd6, 5'd8, 1'b1);

    // Writeback mux sweep
    for (int s = 0; s < 4; s++) begin
      wb_sel = 2'(s);
      push_exp($sformatf("wb_sel_%0d", s), SelWb, 32'(s + 1));
      tick();
    end

    // Reset with a pending character pulse and a concurrent store
    access(1'b1, 3'b010, 8'h30, 32'hDEAD_BEEF);
    tick();
    load_chk("lw_30_before_reset", 3'b010, 8'h30, 32'hDEAD_BEEF);
    access(1'b1, 3'b000, 8'hFF, 32'h0000_005A);
    tick();
    clear = 1'b0;
    access(1'b1, 3'b010, 8'h30, 32'h1122_3344);
    push_exp("char_valid_pre_reset", SelValid, 32'h1);
    push_exp("char_out_pre_reset", SelChar, 32'h5A);
    tick();
    clear = 1'b1;
    access(1'b0, 3'b010, 8'h30, 32'h0);
    push_exp("lw_30_after_reset", SelRdata, 32'h0);
    push_exp("char_out_after_reset", SelChar, 32'h0);
    push_exp("char_valid_after_reset", SelValid, 32'h0);
    tick();
    load_chk("lw_10_after_reset", 3'b010, 8'h10, 32'h0);
    load_chk("lw_fc_after_reset", 3'b010, 8'hFC, 32'h0);
    load_chk("lb_ff_after_reset", 3'b000, 8'hFF, 32'h0);

    // Drain the scoreboard, with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
